// File: rtl/idli_pkg.sv
// Shared types for the idli predicate register file and its serial
// save/restore engine.
package idli_pkg;

    // Compound write operations applied against a predicate's current value.
    typedef enum logic [1:0] {
        PRED_SET = 2'd0,
        PRED_AND = 2'd1,
        PRED_OR  = 2'd2,
        PRED_XOR = 2'd3
    } pred_op_t;

    // Save/restore engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        LOAD = 2'd2
    } pred_ser_state_t;

    // Result of one write-port operation on a single predicate bit.
    function automatic logic pred_apply(input pred_op_t op, input logic old_v, input logic d);
        logic res;
        case (op)
            PRED_SET: res = d;
            PRED_AND: res = old_v & d;
            PRED_OR:  res = old_v | d;
            PRED_XOR: res = old_v ^ d;
            default:  res = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/idli_pred_ser_m.sv
// Bit-serial save/restore engine: walks the writable predicates P0 upward,
// driving each flop value out during SAVE and requesting a load of the
// incoming bit during LOAD.
module idli_pred_ser_m
    import idli_pkg::*;
#(
    parameter int NUM_PREGS = 4,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sv_start,
    input  logic                 ld_start,
    input  logic [NUM_PREGS-2:0] regs,
    output logic [PW-1:0]        idx,
    output logic                 ld_en,
    output logic                 sv_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PREGS - 2);

    pred_ser_state_t state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;

    // Next state: SAVE beats LOAD on a simultaneous start; starts are ignored while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sv_start) begin
                    state_d = SAVE;
                end else if (ld_start) begin
                    state_d = LOAD;
                end
            end
            SAVE, LOAD: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the current state and slot index.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = busy && (cnt_q == LAST_IDX);
        ld_en   = (state_q == LOAD);
        idx     = cnt_q;
        sv_data = 1'b0;
        if (state_q == SAVE) begin
            for (int j = 0; j < NUM_PREGS - 1; j++) begin
                if (cnt_q == PW'(j)) begin
                    sv_data = regs[j];
                end
            end
        end
    end

    // State and slot counter; reset aborts any transfer in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/idli_pred_file_m.sv
// Parametrised predicate register file: chained compound writes, bypassed
// combinational reads, a hardwired-true top predicate and a serial
// save/restore channel for context switches.
module idli_pred_file_m
    import idli_pkg::*;
#(
    parameter int   NUM_PREGS = 4,
    parameter int   NUM_RD    = 2,
    parameter int   NUM_WR    = 2,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic                                 i_pred_gck,
    input  logic                                 i_pred_rst_n,
    input  logic [NUM_RD*$clog2(NUM_PREGS)-1:0]  i_pred_rd,
    output logic [NUM_RD-1:0]                    o_pred_rd_data,
    input  logic [NUM_WR*$clog2(NUM_PREGS)-1:0]  i_pred_wr,
    input  logic [NUM_WR-1:0]                    i_pred_wr_en,
    input  logic [NUM_WR*2-1:0]                  i_pred_wr_op,
    input  logic [NUM_WR-1:0]                    i_pred_wr_data,
    input  logic                                 i_pred_sv_start,
    input  logic                                 i_pred_ld_start,
    input  logic                                 i_pred_ld_data,
    output logic                                 o_pred_sv_data,
    output logic                                 o_pred_busy,
    output logic                                 o_pred_done
);

    localparam int PW = $clog2(NUM_PREGS);
    localparam int NW = NUM_PREGS - 1;   // writable predicates; index NW is always true

    if (NUM_PREGS < 2 || NUM_RD < 1 || NUM_WR < 1) begin : g_bad_params
        $error("idli_pred_file_m: need NUM_PREGS >= 2, NUM_RD >= 1, NUM_WR >= 1");
    end

    logic [NW-1:0] regs_q, regs_d;
    logic [NW-1:0] wr_res;
    logic [PW-1:0] ser_idx;
    logic          ser_ld_en;

    idli_pred_ser_m #(
        .NUM_PREGS (NUM_PREGS),
        .PW        (PW)
    ) u_ser (
        .clk      (i_pred_gck),
        .rst_n    (i_pred_rst_n),
        .sv_start (i_pred_sv_start),
        .ld_start (i_pred_ld_start),
        .regs     (regs_q),
        .idx      (ser_idx),
        .ld_en    (ser_ld_en),
        .sv_data  (o_pred_sv_data),
        .busy     (o_pred_busy),
        .done     (o_pred_done)
    );

    // Apply write ports in order so each port sees the result of the lower ones.
    always_comb begin
        wr_res = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_pred_wr_en[k]) begin
                for (int j = 0; j < NW; j++) begin
                    if (i_pred_wr[k*PW +: PW] == PW'(j)) begin
                        wr_res[j] = pred_apply(pred_op_t'(i_pred_wr_op[k*2 +: 2]),
                                               wr_res[j], i_pred_wr_data[k]);
                    end
                end
            end
        end
    end

    // Restore bit overrides any port write to the slot being loaded.
    always_comb begin
        regs_d = wr_res;
        if (ser_ld_en) begin
            for (int j = 0; j < NW; j++) begin
                if (ser_idx == PW'(j)) begin
                    regs_d[j] = i_pred_ld_data;
                end
            end
        end
    end

    // Read ports see the chained write result; out-of-range and top index read as true.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            o_pred_rd_data[r] = 1'b1;
            for (int j = 0; j < NW; j++) begin
                if (i_pred_rd[r*PW +: PW] == PW'(j)) begin
                    o_pred_rd_data[r] = wr_res[j];
                end
            end
        end
    end

    // Predicate storage.
    always_ff @(posedge i_pred_gck or negedge i_pred_rst_n) begin
        if (!i_pred_rst_n) begin
            regs_q <= {NW{RST_VAL}};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_idli_pred_file_m.sv
// Directed testbench for idli_pred_file_m with NUM_PREGS=4, two read and two
// write ports.
module tb_idli_pred_file_m;
    import idli_pkg::*;

    localparam int NP = 4;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*PW-1:0]  rd;
    logic [NR-1:0]     rd_data;
    logic [NW*PW-1:0]  wr;
    logic [NW-1:0]     wr_en;
    logic [NW*2-1:0]   wr_op;
    logic [NW-1:0]     wr_data;
    logic              sv_start, ld_start, ld_data;
    logic              sv_data, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    idli_pred_file_m #(
        .NUM_PREGS (NP),
        .NUM_RD    (NR),
        .NUM_WR    (NW),
        .RST_VAL   (1'b0)
    ) dut (
        .i_pred_gck      (clk),
        .i_pred_rst_n    (rst_n),
        .i_pred_rd       (rd),
        .o_pred_rd_data  (rd_data),
        .i_pred_wr       (wr),
        .i_pred_wr_en    (wr_en),
        .i_pred_wr_op    (wr_op),
        .i_pred_wr_data  (wr_data),
        .i_pred_sv_start (sv_start),
        .i_pred_ld_start (ld_start),
        .i_pred_ld_data  (ld_data),
        .o_pred_sv_data  (sv_data),
        .o_pred_busy     (busy),
        .o_pred_done     (done)
    );

    always #10 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input int port, input int idx, input logic exp);
        rd[port*PW +: PW] = PW'(idx);
        #1;
        check_bit(tag, rd_data[port], exp);
    endtask

    task automatic chk_regs(input string tag, input logic e0, input logic e1, input logic e2);
        chk_rd({tag, "_p0"}, 0, 0, e0);
        chk_rd({tag, "_p1"}, 1, 1, e1);
        chk_rd({tag, "_p2"}, 0, 2, e2);
    endtask

    task automatic wr_set(input int port, input int idx, input pred_op_t op, input logic d);
        wr[port*PW +: PW]  = PW'(idx);
        wr_op[port*2 +: 2] = op;
        wr_data[port]      = d;
        wr_en[port]        = 1'b1;
    endtask

    task automatic wr_clr();
        wr_en = '0;
    endtask

    task automatic run_save(input string tag, input logic [2:0] bits, input logic clr_p2);
        sv_start = 1'b1;
        tick();
        sv_start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1 && clr_p2) wr_set(0, 2, PRED_SET, 1'b0);
            #1;
            check_bit($sformatf("%s_bit%0d", tag, s), sv_data, bits[s]);
            check_bit($sformatf("%s_busy%0d", tag, s), busy, 1'b1);
            check_bit($sformatf("%s_done%0d", tag, s), done, (s == 2));
            tick();
            wr_clr();
        end
        check_bit({tag, "_busy_end"}, busy, 1'b0);
        check_bit({tag, "_sv_end"}, sv_data, 1'b0);
        check_bit({tag, "_done_end"}, done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rd = '0; wr = '0; wr_en = '0; wr_op = '0; wr_data = '0;
        sv_start = 1'b0; ld_start = 1'b0; ld_data = 1'b0;

        // Reset state
        #25;
        chk_regs("rst", 1'b0, 1'b0, 1'b0);
        chk_rd("rst_p3", 1, 3, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_sv", sv_data, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Chaining and bypass: SET 1 then XOR 1 on P1 -> 0
        wr_set(0, 1, PRED_SET, 1'b1);
        wr_set(1, 1, PRED_XOR, 1'b1);
        chk_rd("byp_chain", 0, 1, 1'b0);
        tick(); wr_clr();
        chk_rd("chain_commit", 0, 1, 1'b0);
        wr_set(0, 2, PRED_OR, 1'b1);
        chk_rd("byp_or", 1, 2, 1'b1);
        tick(); wr_clr();
        chk_rd("or_commit", 1, 2, 1'b1);
        wr_set(0, 2, PRED_AND, 1'b0);
        wr_set(1, 0, PRED_SET, 1'b1);
        chk_rd("byp_and", 0, 2, 1'b0);
        chk_rd("byp_p0", 1, 0, 1'b1);
        tick(); wr_clr();
        wr_set(0, 3, PRED_SET, 1'b0);
        chk_rd("p3_wr_byp", 0, 3, 1'b1);
        tick(); wr_clr();
        chk_rd("p3_wr", 0, 3, 1'b1);
        wr_set(1, 2, PRED_XOR, 1'b1);
        tick(); wr_clr();
        chk_regs("pre_save", 1'b1, 1'b0, 1'b1);

        // Save: plain, then with P2 cleared before its slot
        run_save("save1", 3'b101, 1'b0);
        run_save("save2", 3'b001, 1'b1);
        chk_regs("post_save", 1'b1, 1'b0, 1'b0);

        // Restore 0,1,1 with a conflicting SET P0=1 in the P0 slot
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_data  = 1'b0;
        wr_set(0, 0, PRED_SET, 1'b1);
        #1;
        check_bit("ld_busy0", busy, 1'b1);
        check_bit("ld_done0", done, 1'b0);
        tick(); wr_clr();
        ld_data = 1'b1;
        chk_rd("ld_p0_vis", 0, 0, 1'b0);
        chk_rd("ld_p1_old", 1, 1, 1'b0);
        check_bit("ld_done1", done, 1'b0);
        tick();
        chk_rd("ld_p1_vis", 1, 1, 1'b1);
        check_bit("ld_done2", done, 1'b1);
        tick();
        ld_data = 1'b0;
        check_bit("ld_busy_end", busy, 1'b0);
        chk_regs("ld_final", 1'b0, 1'b1, 1'b1);

        // Arbitration: SAVE wins, ld_start during SAVE ignored
        sv_start = 1'b1; ld_start = 1'b1; ld_data = 1'b0;
        tick();
        sv_start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_bit($sformatf("arb_bit%0d", s), sv_data, (s != 0));
            check_bit($sformatf("arb_done%0d", s), done, (s == 2));
            tick();
        end
        ld_start = 1'b0;
        check_bit("arb_busy_end", busy, 1'b0);
        tick();
        check_bit("arb_busy_idle", busy, 1'b0);
        chk_regs("arb_regs", 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a restore
        wr_set(0, 0, PRED_SET, 1'b0);
        tick(); wr_clr();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_data  = 1'b1;
        tick();
        chk_rd("mid_p0", 0, 0, 1'b1);
        check_bit("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_done", done, 1'b0);
        chk_regs("mid_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bit($sformatf("post_rst_done%0d", c), done, 1'b0);
            check_bit($sformatf("post_rst_busy%0d", c), busy, 1'b0);
        end
        chk_regs("post_rst", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idli_pred_file_m.md
Name: idli_pred_file_m

Overview:
Parametrised successor to the fixed 3+1 predicate register file.
- Configurable predicate count, read-port count and write-port count.
- Compound-predicate write ops: SET/AND/OR/XOR against the current value.
- Asynchronous reset.
- Bit-serial save/restore FSM so the interrupt/context-switch logic can spill and fill all writable predicates over a 1-bit channel.
- Sits beside the core decode/execute logic; read ports gate instruction execution.

Parameters:
NUM_PREGS, 4, total predicates; index NUM_PREGS-1 is hardwired true; must be >= 2.
NUM_RD, 2, number of combinational read ports.
NUM_WR, 2, number of write ports; higher index applied later in the same cycle.
RST_VAL, 1'b0, reset value of every writable predicate.

Ports:
i_pred_gck  in  1  clock (gated core clock)
i_pred_rst_n  in  1  asynchronous active-low reset
i_pred_rd  in  NUM_RD x PW  read indices; PW = $clog2(NUM_PREGS)
o_pred_rd_data  out  NUM_RD  read data
i_pred_wr  in  NUM_WR x PW  write indices
i_pred_wr_en  in  NUM_WR  write enables
i_pred_wr_op  in  NUM_WR x pred_op_t  write operation
i_pred_wr_data  in  NUM_WR  write operand
i_pred_sv_start  in  1  start serial save
i_pred_ld_start  in  1  start serial restore
i_pred_ld_data  in  1  serial restore bit
o_pred_sv_data  out  1  serial save bit
o_pred_busy  out  1  save/restore in progress
o_pred_done  out  1  high during final transfer cycle

Behaviour:
Reset:
- Asserting i_pred_rst_n low immediately sets all writable regs to RST_VAL.
- FSM goes to IDLE; counter is cleared.
- o_pred_busy=0, o_pred_done=0, o_pred_sv_data=0.

Write ops, where old = current value and d = i_pred_wr_data:
- SET: new = d
- AND: new = old & d
- OR: new = old | d
- XOR: new = old ^ d

Write chaining and commit:
- Ports are applied in order 0..NUM_WR-1 within one cycle.
- Port k's "old" is the result after ports 0..k-1, so two writes to one reg in one cycle compose.
- The result commits at the next rising edge.
- Writes to index NUM_PREGS-1 are ignored; reads of it always return 1.

Reads:
- Combinational, zero latency.
- Return the fully chained same-cycle write result (bypass) for the addressed reg; otherwise the flop value.

FSM states: IDLE, SAVE, LOAD. Counter cnt has width PW.
- IDLE:
  - sv_start=1 -> SAVE, cnt=0.
  - Else ld_start=1 -> LOAD, cnt=0.
  - Both asserted: SAVE wins.
- SAVE:
  - o_pred_sv_data = flop value of reg[cnt], P0 first.
  - cnt increments each edge.
  - When cnt==NUM_PREGS-2: o_pred_done=1, and the next edge returns to IDLE.
  - Port writes remain legal; a bit not yet shifted out is sent with its updated value.
- LOAD:
  - At each edge, reg[cnt] <= i_pred_ld_data; this overrides any port write to the same reg that cycle.
  - Other regs remain writable.
  - The restored bit becomes visible on read ports the cycle after its edge.
  - cnt increments; done and exit rules are the same as SAVE.
- o_pred_busy = (state != IDLE).
- sv_start/ld_start while busy are ignored.
- o_pred_sv_data = 0 outside SAVE.
- Transfer length is exactly NUM_PREGS-1 cycles following the start edge.

Reset mid-transfer:
- Aborts to IDLE; regs return to RST_VAL.
- A partial restore is discarded; no done pulse.

Elaboration assertion: NUM_PREGS >= 2, NUM_RD >= 1, NUM_WR >= 1.

Decomposition:
Shared package idli_pkg:
- pred_op_t enum (2-bit: PRED_SET, PRED_AND, PRED_OR, PRED_XOR).
- pred_ser_state_t enum (IDLE/SAVE/LOAD).

Sub-module idli_pred_ser_m:
- Owns the FSM, counter, busy/done and serial-out mux.
- Exports the current index plus a load-enable to the parent.
- The parent holds the register array, write-op chaining and read bypass.

Test Plan:
1. Reset then read all: NUM_PREGS=4, rst_n low -> rd of P0..P2 = 0, P3 = 1, busy=0.
2. Same-cycle bypass and chaining: P1=0; port0 SET P1=1, port1 XOR P1=1 same cycle -> rd P1 = 0 that cycle, flop P1 = 0 after edge. Port0 OR P2=1 -> rd P2 = 1 immediately. Write P3=0 -> rd P3 stays 1.
3. Save: P0..P2 = 1,0,1; pulse sv_start -> sv_data 1,0,1 over 3 cycles, done high in third, busy low after. Mid-save SET P2=0 before its slot -> third bit = 0.
4. Restore with conflict: ld_start, ld_data 0,1,1; port0 SET P0=1 in the P0 slot -> final P0..P2 = 0,1,1.
5. Arbitration: sv_start and ld_start same cycle -> SAVE; ld_start during SAVE ignored, regs unchanged.
6. Reset mid-LOAD after 1 bit -> regs = RST_VAL, busy=0, no done pulse.
